fp_add_align_stage: RTL



---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_align_shift.sv | 30 +++
 rtl/fp_add_align_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 field widths, rounding-mode encodings and the aligned-operand
// record passed between the align stage and its output buffer.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int ALIGN_W = 27;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef struct packed {
    logic               sign_big;
    logic               eff_sub;
    logic [EXP_W-1:0]   exp_big;
    logic [ALIGN_W-1:0] mant_big;
    logic [ALIGN_W-1:0] mant_small;
    logic               exact_zero;
    logic               special;
    logic [31:0]        special_res;
    logic               nv;
    logic [2:0]         rm;
  } fp_align_t;

endpackage

// File: rtl/fp_align_shift.sv
// 27-bit right shifter; every bit shifted out is ORed into bit 0 (sticky).
module fp_align_shift
  import fp_pkg::*;
(
  input  logic [ALIGN_W-1:0] mant,
  input  logic [EXP_W-1:0]   d,
  output logic [ALIGN_W-1:0] aligned
);

  logic [ALIGN_W-1:0] shifted;
  logic [ALIGN_W-1:0] lost_mask;
  logic               sticky;

  // shift with sticky collapse; huge distances leave only the sticky bit
  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    aligned   = '0;
    if (d >= 8'(ALIGN_W)) begin
      aligned = {{(ALIGN_W-1){1'b0}}, |mant};
    end else begin
      shifted   = mant >> d;
      lost_mask = ~({ALIGN_W{1'b1}} << d);
      sticky    = |(mant & lost_mask);
      aligned   = {shifted[ALIGN_W-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/fp_add_align_stage.sv
// FP32 add/sub front end: unpack, classify specials, order by magnitude and
// align the smaller mantissa, registered behind a main/skid output buffer.
module fp_add_align_stage
  import fp_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int SKID_EN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                add_sub,
  input  logic [31:0]         op_a,
  input  logic [31:0]         op_b,
  input  logic [2:0]          rm,
  input  logic [TAG_W-1:0]    tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign_big,
  output logic                eff_sub,
  output logic [EXP_W-1:0]    exp_big,
  output logic [ALIGN_W-1:0]  mant_big,
  output logic [ALIGN_W-1:0]  mant_small,
  output logic                exact_zero,
  output logic                special,
  output logic [31:0]         special_res,
  output logic                nv,
  output logic [2:0]          rm_out,
  output logic [TAG_W-1:0]    tag_out
);

  logic               sign_a, sign_b;
  logic [EXP_W-1:0]   exp_a, exp_b, eexp_a, eexp_b;
  logic [FRAC_W-1:0]  frac_a, frac_b;
  logic [ALIGN_W-1:0] mant_a, mant_b, small_mant;
  logic [EXP_W-1:0]   small_exp, shift_d;
  logic [ALIGN_W-1:0] small_aligned;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  fp_align_t          new_entry;

  fp_align_t          main_q, main_d, skid_q, skid_d;
  logic [TAG_W-1:0]   main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic               main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               accept, drain;

  // unpack, classify and order operands by magnitude (tie keeps A as big)
  always_comb begin
    sign_a = op_a[31];
    sign_b = op_b[31] ^ add_sub;
    exp_a  = op_a[30:23];
    exp_b  = op_b[30:23];
    frac_a = op_a[22:0];
    frac_b = op_b[22:0];
    eexp_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
    eexp_b = (exp_b == 8'd0) ? 8'd1 : exp_b;
    mant_a = {(exp_a != 8'd0), frac_a, 3'b000};
    mant_b = {(exp_b != 8'd0), frac_b, 3'b000};
    a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    a_zero = (op_a[30:0] == 31'd0);
    b_zero = (op_b[30:0] == 31'd0);
    swap   = (op_b[30:0] > op_a[30:0]);

    new_entry         = '0;
    new_entry.eff_sub = sign_a ^ sign_b;
    new_entry.rm      = rm;
    if (swap) begin
      new_entry.sign_big = sign_b;
      new_entry.exp_big  = eexp_b;
      new_entry.mant_big = mant_b;
      small_exp          = eexp_a;
      small_mant         = mant_a;
    end else begin
      new_entry.sign_big = sign_a;
      new_entry.exp_big  = eexp_a;
      new_entry.mant_big = mant_a;
      small_exp          = eexp_b;
      small_mant         = mant_b;
    end
    shift_d = new_entry.exp_big - small_exp;
    new_entry.mant_small = small_aligned;
    new_entry.exact_zero = (new_entry.eff_sub && (op_a[30:0] == op_b[30:0])) ||
                           (a_zero && b_zero);

    if (a_nan || b_nan) begin
      new_entry.special     = 1'b1;
      new_entry.special_res = CANON_NAN;
      new_entry.nv          = (a_nan && !frac_a[22]) || (b_nan && !frac_b[22]);
    end else if (a_inf && b_inf && new_entry.eff_sub) begin
      new_entry.special     = 1'b1;
      new_entry.special_res = CANON_NAN;
      new_entry.nv          = 1'b1;
    end else if (a_inf) begin
      new_entry.special     = 1'b1;
      new_entry.special_res = {sign_a, 8'hFF, 23'd0};
    end else if (b_inf) begin
      new_entry.special     = 1'b1;
      new_entry.special_res = {sign_b, 8'hFF, 23'd0};
    end else begin
      new_entry.special     = 1'b0;
    end
  end

  fp_align_shift u_shift (
    .mant    (small_mant),
    .d       (shift_d),
    .aligned (small_aligned)
  );

  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;
  assign in_ready = (SKID_EN != 0) ? in_ready_q : (!main_valid_q || out_ready);

  // buffer next state; skid only fills while main is held, and refills main first
  always_comb begin
    main_d       = main_q;
    main_tag_d   = main_tag_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_tag_d   = skid_tag_q;
    skid_valid_d = skid_valid_q;
    if (SKID_EN != 0) begin
      if (drain) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_tag_d   = skid_tag_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = new_entry;
          main_tag_d   = tag_in;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (main_valid_q) begin
          skid_d       = new_entry;
          skid_tag_d   = tag_in;
          skid_valid_d = 1'b1;
        end else begin
          main_d       = new_entry;
          main_tag_d   = tag_in;
          main_valid_d = 1'b1;
        end
      end else begin
        main_valid_d = main_valid_q;
      end
    end else begin
      if (accept) begin
        main_d       = new_entry;
        main_tag_d   = tag_in;
        main_valid_d = 1'b1;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  // buffer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_q       <= '0;
      main_tag_q   <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_tag_q   <= main_tag_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_tag_q   <= skid_tag_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign sign_big    = main_q.sign_big;
  assign eff_sub     = main_q.eff_sub;
  assign exp_big     = main_q.exp_big;
  assign mant_big    = main_q.mant_big;
  assign mant_small  = main_q.mant_small;
  assign exact_zero  = main_q.exact_zero;
  assign special     = main_q.special;
  assign special_res = main_q.special_res;
  assign nv          = main_q.nv;
  assign rm_out      = main_q.rm;
  assign tag_out     = main_tag_q;

endmodule
